// File: rtl/dff_response_checker.sv
// rtl/dff_response_checker.sv - Observes the stimulus and Q of a D flip-flop DUT and checks Q against a replayed expected pipeline.
module dff_response_checker #(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_checks,
    input  logic [WIDTH-1:0] d_obs,
    input  logic             dut_rst_obs,
    input  logic [WIDTH-1:0] q_obs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_act,
    output logic             first_err_vld
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pipe_q [LATENCY];
    logic [WIDTH-1:0] pipe_d [LATENCY];
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [3:0]       fill_q, fill_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] fe_idx_q, fe_idx_d;
    logic [WIDTH-1:0] fe_exp_q, fe_exp_d;
    logic [WIDTH-1:0] fe_act_q, fe_act_d;
    logic             fe_vld_q, fe_vld_d;

    logic [WIDTH-1:0] exp_cmp;
    logic             mismatch;
    logic [CNT_W-1:0] cmp_idx;

    assign exp_cmp  = pipe_q[LATENCY-1];
    // Case inequality so X/Z on the DUT output is flagged in simulation.
    assign mismatch = (q_obs !== exp_cmp);
    assign cmp_idx  = num_q - remaining_q;

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        remaining_d = remaining_q;
        fill_d      = fill_q;
        err_cnt_d   = err_cnt_q;
        pass_d      = pass_q;
        fe_idx_d    = fe_idx_q;
        fe_exp_d    = fe_exp_q;
        fe_act_d    = fe_act_q;
        fe_vld_d    = fe_vld_q;

        // The expected pipeline runs every cycle so it is primed before any run.
        pipe_d[0] = dut_rst_obs ? '0 : d_obs;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_cnt_d = '0;
                    pass_d    = 1'b0;
                    fe_idx_d  = '0;
                    fe_exp_d  = '0;
                    fe_act_d  = '0;
                    fe_vld_d  = 1'b0;
                    if (num_checks == '0) begin
                        pass_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        num_d       = num_checks;
                        remaining_d = num_checks;
                        fill_d      = '0;
                        state_d     = S_FILL;
                    end
                end
            end
            S_FILL: begin
                fill_d = fill_q + 4'd1;
                if (fill_q == 4'(LATENCY - 1)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                remaining_d = remaining_q - 1'b1;
                if (mismatch) begin
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (!fe_vld_q) begin
                        fe_idx_d = cmp_idx;
                        fe_exp_d = exp_cmp;
                        fe_act_d = q_obs;
                        fe_vld_d = 1'b1;
                    end
                end
                if (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    pass_d  = (err_cnt_d == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            num_q       <= '0;
            remaining_q <= '0;
            fill_q      <= '0;
            err_cnt_q   <= '0;
            pass_q      <= 1'b0;
            fe_idx_q    <= '0;
            fe_exp_q    <= '0;
            fe_act_q    <= '0;
            fe_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            num_q       <= num_d;
            remaining_q <= remaining_d;
            fill_q      <= fill_d;
            err_cnt_q   <= err_cnt_d;
            pass_q      <= pass_d;
            fe_idx_q    <= fe_idx_d;
            fe_exp_q    <= fe_exp_d;
            fe_act_q    <= fe_act_d;
            fe_vld_q    <= fe_vld_d;
        end
    end

    assign busy          = (state_q == S_FILL) || (state_q == S_CHECK);
    assign done          = (state_q == S_DONE);
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = fe_idx_q;
    assign first_err_exp = fe_exp_q;
    assign first_err_act = fe_act_q;
    assign first_err_vld = fe_vld_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// tb/tb_dff_response_checker.sv - Directed bench: a 1-bit/latency-1 checker and an 8-bit/latency-3 checker beside bench DUT models.
module tb_dff_response_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start_a = 1'b0;
    logic [15:0] num_a = '0;
    logic [0:0]  d_a = '0;
    logic        drst_a = 1'b0;
    logic [0:0]  q_a;
    logic        busy_a, done_a, pass_a, vld_a;
    logic [15:0] err_a, idx_a;
    logic [0:0]  exp_a, act_a;

    logic        start_b = 1'b0;
    logic [15:0] num_b = '0;
    logic [7:0]  d_b = '0;
    logic [7:0]  q_b;
    logic        busy_b, done_b, pass_b, vld_b;
    logic [15:0] err_b, idx_b;
    logic [7:0]  exp_b, act_b;

    logic        dff_a = 1'b0;
    logic        force_a = 1'b0;
    logic        ign_rst = 1'b0;
    logic [7:0]  s1 = '0, s2 = '0, s3 = '0;
    logic        sel2 = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) dff_a <= (drst_a && !ign_rst) ? 1'b0 : d_a[0];
    assign q_a = force_a ? 1'b1 : dff_a;

    always @(posedge clk) begin
        s1 <= d_b;
        s2 <= s1;
        s3 <= s2;
    end
    assign q_b = sel2 ? s2 : s3;

    dff_response_checker #(.WIDTH(1), .LATENCY(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .num_checks(num_a),
        .d_obs(d_a), .dut_rst_obs(drst_a), .q_obs(q_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
        .first_err_idx(idx_a), .first_err_exp(exp_a), .first_err_act(act_a),
        .first_err_vld(vld_a)
    );

    dff_response_checker #(.WIDTH(8), .LATENCY(3), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .num_checks(num_b),
        .d_obs(d_b), .dut_rst_obs(1'b0), .q_obs(q_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
        .first_err_idx(idx_b), .first_err_exp(exp_b), .first_err_act(act_b),
        .first_err_vld(vld_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // dmode: 0 -> D=0, 1 -> D toggles, 2 -> D=1. Period p=0 is the first FILL cycle;
    // with latency 1 comparison k sees the push of period k and happens in period k+1.
    task automatic run_a(input string nm, input int n, input int dmode, input int rlo, input int rhi,
                         input logic [15:0] fmask, input logic ign, input int sp,
                         input int e_err, input int e_idx, input logic e_vld, input logic e_act,
                         input logic e_pass);
        int done_p;
        done_p = (n == 0) ? 0 : n + 1;
        ign_rst = ign;
        start_a = 1'b1;
        num_a   = 16'(n);
        next_cyc();
        start_a = 1'b0;
        for (int p = 0; p <= done_p; p++) begin
            d_a[0]  = (dmode == 0) ? 1'b0 : (dmode == 1) ? p[0] : 1'b1;
            drst_a  = (p >= rlo) && (p <= rhi);
            force_a = (p >= 1 && p <= 16) ? fmask[p-1] : 1'b0;
            start_a = (p == sp);
            num_a   = (p == sp) ? 16'd3 : 16'(n);
            @(negedge clk);
            if (p == 0 && n != 0) chk({nm, "_busy"}, busy_a, 1);
            if (p == done_p - 1) chk({nm, "_done_early"}, done_a, 0);
            if (p == done_p) begin
                chk({nm, "_done"}, done_a, 1);
                chk({nm, "_busy_end"}, busy_a, 0);
                chk({nm, "_pass"}, pass_a, e_pass);
                chk({nm, "_err"}, err_a, e_err);
                chk({nm, "_vld"}, vld_a, e_vld);
                chk({nm, "_idx"}, idx_a, e_idx);
                chk({nm, "_exp"}, exp_a, 0);
                chk({nm, "_act"}, act_a, e_act);
            end
            next_cyc();
        end
        start_a = 1'b0;
        drst_a  = 1'b0;
        force_a = 1'b0;
        ign_rst = 1'b0;
        @(negedge clk);
        chk({nm, "_done_once"}, done_a, 0);
        chk({nm, "_pass_hold"}, pass_a, e_pass);
        next_cyc();
    endtask

    // D counts 0,1,2,... from the first FILL cycle; comparison k happens in period k+3.
    task automatic run_b(input string nm, input logic two_stage, input int e_err, input logic e_pass,
                         input logic [7:0] e_act);
        sel2    = two_stage;
        start_b = 1'b1;
        num_b   = 16'd10;
        next_cyc();
        start_b = 1'b0;
        for (int p = 0; p <= 13; p++) begin
            d_b = 8'(p);
            @(negedge clk);
            if (p == 12) chk({nm, "_done_early"}, done_b, 0);
            if (p == 13) begin
                chk({nm, "_done"}, done_b, 1);
                chk({nm, "_pass"}, pass_b, e_pass);
                chk({nm, "_err"}, err_b, e_err);
                chk({nm, "_idx"}, idx_b, 0);
                chk({nm, "_act"}, act_b, e_act);
            end
            next_cyc();
        end
    endtask

    initial begin
        int done_seen;
        repeat (2) next_cyc();
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_vld", vld_a, 0);
        chk("rst_b_err", err_b, 0);
        rst = 1'b0;
        next_cyc();

        run_a("clean", 10, 1, 99, 99, 16'h0000, 1'b0, -1, 0, 0, 1'b0, 1'b0, 1'b1);
        run_a("fault", 10, 0, 99, 99, 16'h0088, 1'b0, -1, 2, 3, 1'b1, 1'b1, 1'b0);
        run_a("dutrst", 10, 2, 4, 5, 16'h0000, 1'b0, -1, 0, 0, 1'b0, 1'b0, 1'b1);
        run_a("dutrst_bad", 10, 2, 4, 5, 16'h0000, 1'b1, -1, 2, 4, 1'b1, 1'b1, 1'b0);
        run_a("zero", 0, 0, 99, 99, 16'h0000, 1'b0, -1, 0, 0, 1'b0, 1'b0, 1'b1);
        run_a("restart", 10, 1, 99, 99, 16'h0000, 1'b0, 5, 0, 0, 1'b0, 1'b0, 1'b1);

        run_b("lat3", 1'b0, 0, 1'b1, 8'h00);
        run_b("lat2", 1'b1, 10, 1'b0, 8'h01);

        // Abort: one mismatch at comparison 2, then reset mid-CHECK.
        start_a = 1'b1;
        num_a   = 16'd10;
        d_a     = '0;
        next_cyc();
        start_a = 1'b0;
        for (int p = 0; p <= 4; p++) begin
            force_a = (p == 3);
            @(negedge clk);
            if (p == 4) begin
                chk("abort_pre_err", err_a, 1);
                chk("abort_pre_busy", busy_a, 1);
            end
            next_cyc();
        end
        rst = 1'b1;
        #1;
        chk("abort_busy", busy_a, 0);
        chk("abort_err", err_a, 0);
        chk("abort_vld", vld_a, 0);
        chk("abort_idx", idx_a, 0);
        chk("abort_act", act_a, 0);
        chk("abort_pass", pass_a, 0);
        chk("abort_done", done_a, 0);
        next_cyc();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done_a === 1'b1) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        next_cyc();
        run_a("after_abort", 4, 1, 99, 99, 16'h0000, 1'b0, -1, 0, 0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
